// File: rtl/uart_tx_mmio_pkg.sv
// uart_regs: shared definitions for the memory-mapped UART transmitter.
//   - register offsets within the 4-byte register window
//   - STATUS and CTRL bit positions
//   - TX serialiser state type
package uart_regs;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;

    // STATUS bits; the fill count occupies [7:4]
    localparam int StFull    = 0;
    localparam int StEmpty   = 1;
    localparam int StBusy    = 2;
    localparam int StOvf     = 3;
    localparam int StCountLo = 4;

    // CTRL bits; flush and ovf_clr are write-1 pulses and read back 0
    localparam int CtrlTxEn   = 0;
    localparam int CtrlIrqEn  = 1;
    localparam int CtrlFlush  = 2;
    localparam int CtrlOvfClr = 3;

    typedef enum logic [1:0] {
        TxIdle  = 2'd0,
        TxStart = 2'd1,
        TxData  = 2'd2,
        TxStop  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read.
//   clk_in, reset (async, active-low)
//   push/wdata : enqueue; ignored when full unless a pop happens in the same cycle
//   pop        : dequeue head; ignored when empty
//   flush      : empties the FIFO, takes priority over a simultaneous push
//   rdata      : current head entry
//   full, empty, count (0..DEPTH)
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter for the cpu6502 bus.
//   clk_in, reset (async, active-low)
//   address_in, data_in, READ_write : CPU bus (READ_write 1 = write)
//   data_out    : combinational read data, 8'h00 when not selected
//   selected    : combinational, address_in within BASE_ADDR..BASE_ADDR+3
//   tx_out      : registered serial line, idle high
//   tx_idle_irq : registered, FIFO empty and serialiser idle with irq_en set
//
// state   | meaning
// TxIdle  | line high; pops the FIFO head when tx_en and data available
// TxStart | start bit (low) for CLKS_PER_BIT cycles
// TxData  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// TxStop  | stop bit (high) for CLKS_PER_BIT cycles, then back to TxIdle
module uart_tx_mmio
    import uart_regs::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h8000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] address_in,
    input  logic [7:0]  data_in,
    input  logic        READ_write,
    output logic [7:0]  data_out,
    output logic        selected,
    output logic        tx_out,
    output logic        tx_idle_irq
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);

    logic [1:0]    reg_off;
    logic          wr_en;
    logic          data_wr;
    logic          ctrl_wr;
    logic          flush;
    logic          ovf_clr;
    logic          tx_en;
    logic          irq_en;
    logic          ovf;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    status;
    tx_state_t     state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_last;

    assign selected = (address_in[15:2] == BASE_ADDR[15:2]);
    assign reg_off  = address_in[1:0];
    assign wr_en    = selected && READ_write;
    assign data_wr  = wr_en && (reg_off == RegData);
    assign ctrl_wr  = wr_en && (reg_off == RegCtrl);
    assign flush    = ctrl_wr && data_in[CtrlFlush];
    assign ovf_clr  = ctrl_wr && data_in[CtrlOvfClr];
    assign fifo_pop = (state == TxIdle) && tx_en && !fifo_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in (clk_in),
        .reset  (reset),
        .push   (data_wr),
        .pop    (fifo_pop),
        .flush  (flush),
        .wdata  (data_in),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tx_en       <= 1'b1;
            irq_en      <= 1'b0;
            ovf         <= 1'b0;
            tx_idle_irq <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                tx_en  <= data_in[CtrlTxEn];
                irq_en <= data_in[CtrlIrqEn];
            end
            // A dropped byte on the same edge as ovf_clr keeps the flag set.
            if (data_wr && fifo_full && !fifo_pop) ovf <= 1'b1;
            else if (ovf_clr)                      ovf <= 1'b0;
            tx_idle_irq <= fifo_empty && (state == TxIdle) && irq_en;
        end
    end

    assign baud_last = (baud == BaudLast);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= TxIdle;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_out  <= 1'b1;
        end else begin
            case (state)
                TxIdle: begin
                    baud <= '0;
                    if (fifo_pop) begin
                        state  <= TxStart;
                        shift  <= fifo_rdata;
                        tx_out <= 1'b0;
                    end
                end
                TxStart: begin
                    if (baud_last) begin
                        state   <= TxData;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx_out  <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TxData: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state  <= TxStop;
                            tx_out <= 1'b1;
                        end else begin
                            // shift[0] is on the line; shift[1] is the next bit.
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx_out  <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TxStop: begin
                    if (baud_last) begin
                        state <= TxIdle;
                        baud  <= '0;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state  <= TxIdle;
                    baud   <= '0;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        status                    = '0;
        status[StFull]            = fifo_full;
        status[StEmpty]           = fifo_empty;
        status[StBusy]            = (state != TxIdle);
        status[StOvf]             = ovf;
        status[StCountLo +: 4]    = 4'(fifo_count);
    end

    always_comb begin
        data_out = 8'h00;
        if (selected) begin
            case (reg_off)
                RegStatus: data_out = status;
                RegCtrl:   data_out = {6'b0, irq_en, tx_en};
                default:   data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address_in = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        READ_write = 1'b0;
    logic [7:0]  data_out;
    logic        selected;
    logic        tx_out;
    logic        tx_idle_irq;

    uart_tx_mmio #(
        .BASE_ADDR    (16'h8000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .address_in  (address_in),
        .data_in     (data_in),
        .READ_write  (READ_write),
        .data_out    (data_out),
        .selected    (selected),
        .tx_out      (tx_out),
        .tx_idle_irq (tx_idle_irq)
    );

    always #5 clk_in = ~clk_in;

    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;
    logic [7:0] mon_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_in);
        address_in = a;
        data_in    = d;
        READ_write = 1'b1;
        @(posedge clk_in);
        #1;
        READ_write = 1'b0;
        address_in = 16'h0000;
        data_in    = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
        @(negedge clk_in);
        address_in = a;
        READ_write = 1'b0;
        #1;
        d = data_out;
        s = selected;
    endtask

    task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       s;
        bus_read(a, d, s);
        chk(name, {24'h0, d}, {24'h0, exp});
    endtask

    // Reference model: bytes held while transmit is disabled. Capacity DEPTH,
    // extra pushes are lost and flag overflow.
    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    task automatic model_release();
        while (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
    endtask

    function automatic logic [7:0] exp_status();
        int n;
        n = model_q.size();
        return {4'(n), model_ovf, 1'b0, (n == 0), (n == DEPTH)};
    endfunction

    task automatic wait_drain(input string name);
        for (int i = 0; i < 1500 && exp_q.size() != 0; i++) @(posedge clk_in);
        chk(name, exp_q.size(), 0);
        repeat (6) @(posedge clk_in);
        #1;
    endtask

    // Monitor: decodes each frame at mid-bit and checks it against the queue.
    initial begin
        forever begin
            @(negedge tx_out);
            if (mon_en && reset) begin
                repeat (CPB / 2) @(posedge clk_in);
                #1;
                chk("start_bit", {31'h0, tx_out}, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk_in);
                    #1;
                    mon_byte[i] = tx_out;
                end
                repeat (CPB) @(posedge clk_in);
                #1;
                chk("stop_bit", {31'h0, tx_out}, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %02h expected no frame", mon_byte);
                end else begin
                    chk("frame_byte", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s;
        logic [7:0] b;
        int         n;
        bit         extra;

        // reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_tx_out", {31'h0, tx_out}, 1);
        chk("rst_irq", {31'h0, tx_idle_irq}, 0);
        @(negedge clk_in);
        reset = 1'b1;
        read_chk("rst_status", 16'h8001, 8'h02);
        read_chk("rst_ctrl", 16'h8002, 8'h01);

        // 1: single frame, latency and idle status after 41 cycles
        exp_q.push_back(8'hA5);
        bus_write(16'h8000, 8'hA5);
        chk("t1_line_before_pop", {31'h0, tx_out}, 1);
        @(posedge clk_in);
        #1;
        chk("t1_start_low", {31'h0, tx_out}, 0);
        repeat (40) @(posedge clk_in);
        #1;
        read_chk("t1_status_idle", 16'h8001, 8'h02);
        chk("t1_frame_seen", exp_q.size(), 0);

        // 2: overflow with transmit disabled, only first DEPTH bytes sent
        bus_write(16'h8002, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            model_push(8'(i));
            bus_write(16'h8000, 8'(i));
        end
        read_chk("t2_status_full", 16'h8001, exp_status());
        read_chk("t2_status_49", 16'h8001, 8'h49);
        model_release();
        bus_write(16'h8002, 8'h01);
        wait_drain("t2_drain");
        read_chk("t2_status_after", 16'h8001, exp_status());

        // 3: ovf_clr, then overflow again, then flush with clear
        bus_write(16'h8002, 8'h08);
        model_ovf = 1'b0;
        read_chk("t3_ovf_cleared", 16'h8001, exp_status());
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            model_push(b);
            bus_write(16'h8000, b);
        end
        read_chk("t3_ovf_set", 16'h8001, exp_status());
        bus_write(16'h8002, 8'h0C);
        model_q.delete();
        model_ovf = 1'b0;
        read_chk("t3_flushed", 16'h8001, exp_status());

        // 4: flush during a frame: current frame completes, queued byte lost
        bus_write(16'h8002, 8'h01);
        exp_q.push_back(8'h11);
        bus_write(16'h8000, 8'h11);
        bus_write(16'h8000, 8'h22);
        repeat (10) @(posedge clk_in);
        bus_write(16'h8002, 8'h05);
        wait_drain("t4_drain");
        repeat (50) @(posedge clk_in);
        read_chk("t4_status", 16'h8001, 8'h02);

        // 5: asynchronous reset in data bit 3 (a zero bit of 8'hA5)
        mon_en = 1'b0;
        bus_write(16'h8000, 8'hA5);
        repeat (18) @(posedge clk_in);
        #1;
        chk("t5_bit3_low", {31'h0, tx_out}, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_async_line_high", {31'h0, tx_out}, 1);
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        mon_en = 1'b1;
        read_chk("t5_status", 16'h8001, 8'h02);
        read_chk("t5_ctrl", 16'h8002, 8'h01);
        chk("t5_irq", {31'h0, tx_idle_irq}, 0);

        // 6: address decode and idle interrupt
        bus_read(16'h8004, d, s);
        chk("t6_8004_sel", {31'h0, s}, 0);
        chk("t6_8004_data", {24'h0, d}, 0);
        bus_read(16'h7FFF, d, s);
        chk("t6_7fff_sel", {31'h0, s}, 0);
        chk("t6_7fff_data", {24'h0, d}, 0);
        bus_read(16'h8003, d, s);
        chk("t6_8003_sel", {31'h0, s}, 1);
        chk("t6_8003_data", {24'h0, d}, 0);
        read_chk("t6_data_reads_0", 16'h8000, 8'h00);
        bus_write(16'h8002, 8'h03);
        repeat (2) @(posedge clk_in);
        #1;
        chk("t6_irq", {31'h0, tx_idle_irq}, 1);
        read_chk("t6_ctrl", 16'h8002, 8'h03);

        // random bursts; optionally a push lands on the first pop edge, where
        // a full FIFO still accepts it without overflow
        for (int r = 0; r < 8; r++) begin
            bus_write(16'h8002, 8'h00);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                model_push(b);
                bus_write(16'h8000, b);
            end
            read_chk("rnd_status_loaded", 16'h8001, exp_status());
            extra = 1'($urandom);
            model_release();
            model_ovf = 1'b0;
            bus_write(16'h8002, 8'h09);
            if (extra) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(16'h8000, b);
            end
            wait_drain("rnd_drain");
            read_chk("rnd_status_idle", 16'h8001, exp_status());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
